perf_counter_unit: RTL and testbench
====================================

PERF_COUNTER_UNIT -- requirements
Module: perf_counter_unit

Interface
REQ-001 Parameter NUM_CH, default 4, number of event channels (1..16).
REQ-002 Parameter CNT_W, default 32, width of every counter (8..64).
REQ-003 Parameter SEL_W, default $clog2(NUM_CH+2), width of the readout index.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  asynchronous reset, active-low.
REQ-006 start  input  1  pulse: begin counting from IDLE.
REQ-007 clear  input  1  pulse: zero all counters and flags, return to IDLE.
REQ-008 retire  input  1  one instruction retired this cycle.
REQ-009 halt  input  1  halt instruction retired this cycle.
REQ-010 ev  input  NUM_CH  per-channel event strobes, e.g. icache req/hit, dcache req/hit.
REQ-011 rd_req  input  1  readout request.
REQ-012 rd_sel  input  SEL_W  counter index: 0 cycles, 1 instructions, 2..NUM_CH+1 channels.
REQ-013 rd_valid  output  1  readout data valid.
REQ-014 rd_data  output  CNT_W  selected counter value.
REQ-015 ovf  output  NUM_CH+2  sticky overflow flag per counter, same indexing as rd_sel.
REQ-016 running  output  1  high in RUN state.
REQ-017 frozen  output  1  high in FROZEN state.

Function
REQ-018 The state machine SHALL have states IDLE, RUN and FROZEN.
REQ-019 IDLE->RUN on start; RUN->FROZEN on halt; FROZEN and RUN->IDLE on clear; all other cases hold the current state.
REQ-020 In RUN, counter 0 SHALL increment every cycle, counter 1 on (retire|halt), and counter k+2 on ev[k].
REQ-021 The halt cycle SHALL be counted in full (cycle, instruction, events); from the next cycle on, no counter changes.
REQ-022 In IDLE and FROZEN, counters SHALL hold their values.
REQ-023 start in IDLE SHALL NOT count its own cycle; counting begins on the following cycle.
REQ-024 clear SHALL override start, halt and events in the same cycle: counters become 0, ovf becomes 0, and the state becomes IDLE.
REQ-025 A counter at all-ones that receives an increment SHALL set its ovf bit; the value then follows REQ-032.
REQ-026 Readout latency SHALL be 1 cycle: rd_req at cycle N gives rd_valid=1 at cycle N+1 with the value held before cycle N's update.
REQ-027 Back-to-back rd_req SHALL be accepted every cycle.
REQ-028 An rd_sel above NUM_CH+1 SHALL return rd_data=0 with rd_valid=1.
REQ-029 rd_valid SHALL be 0 in any cycle following a cycle without rd_req.
REQ-030 rd_data SHALL be 0 whenever rd_valid is 0.

Reset
REQ-031 While rst=0, the block SHALL immediately hold state IDLE, all counters 0, ovf 0, rd_valid 0, rd_data 0, running 0 and frozen 0, including when asserted mid-count or mid-readout.

Configuration
REQ-032 With PERF_SATURATE_EN defined, counters SHALL saturate at 2^CNT_W-1; without it, counters SHALL wrap to 0. ovf behaviour SHALL be identical in both builds.

Structure
REQ-033 Package perf_pkg SHALL hold the state enum and the index constants CYC_IDX=0 and INST_IDX=1.
REQ-034 A single-counter sub-module perf_ctr SHALL be used: inputs inc and clr, outputs value and ovf, with the saturate/wrap option resolved inside it. It SHALL be instantiated NUM_CH+2 times.

Verification
REQ-035 Scenario 1: reset, start, then 10 cycles with retire=1 and ev=4'b0101, then halt -> counter 0=11, counter 1=11, ch0=10, ch2=10, ch1=0, frozen=1.
REQ-036 Scenario 2: after FROZEN, 20 more cycles of events -> every counter is unchanged on readout.
REQ-037 Scenario 3: CNT_W=8, ch0 strobed 257 times -> ovf[2]=1; rd_data=255 with PERF_SATURATE_EN defined, rd_data=1 without it.
REQ-038 Scenario 4: clear asserted together with halt and ev=4'hF -> all counters 0, ovf 0, state IDLE.
REQ-039 Scenario 5: rd_req with rd_sel=1 in the same cycle as retire, with counter 1=5 -> next cycle rd_valid=1 and rd_data=5; rd_sel=7 with NUM_CH=4 -> rd_data=0.
REQ-040 Scenario 6: rst dropped mid-RUN while a readout is pending -> all outputs are 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared types and counter index constants for the performance counter unit.
package perf_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } perf_state_t;

  localparam int CYC_IDX  = 0;
  localparam int INST_IDX = 1;
  // Channel k lives at counter index k + CH_BASE.
  localparam int CH_BASE  = 2;

endpackage

// File: rtl/perf_ctr.sv
// Single sticky-overflow event counter.
// Build option PERF_SATURATE_EN: saturate at all-ones instead of wrapping to 0.
module perf_ctr
  import perf_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] value,
  output logic             ovf
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      value <= '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      if (&value) begin
        ovf <= 1'b1;
`ifdef PERF_SATURATE_EN
        value <= value;
`else
        value <= '0;
`endif
      end else begin
        value <= value + 1'b1;
      end
    end
  end

endmodule

// File: rtl/perf_counter_unit.sv
// Cycle/instruction/event performance counters with a run/freeze FSM and a
// one-cycle registered readout port.
module perf_counter_unit
  import perf_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int SEL_W  = $clog2(NUM_CH + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear,
  input  logic              retire,
  input  logic              halt,
  input  logic [NUM_CH-1:0] ev,
  input  logic              rd_req,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH+1:0] ovf,
  output logic              running,
  output logic              frozen
);

  localparam int NUM_CTR = NUM_CH + 2;

  perf_state_t       state;
  logic              countEn;
  logic [NUM_CTR-1:0] ctrInc;
  logic [CNT_W-1:0]  ctrVal [NUM_CTR];
  logic [CNT_W-1:0]  selData;

  // NOTE: async reset clears every flop, so outputs drop to 0 the instant rst falls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      running <= 1'b0;
      frozen  <= 1'b0;
    end else begin
      if (clear) begin
        state   <= IDLE;
        running <= 1'b0;
        frozen  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            state   <= RUN;
            running <= 1'b1;
          end
          RUN: if (halt) begin
            state   <= FROZEN;
            running <= 1'b0;
            frozen  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // The halt cycle itself still counts; clear wins over everything.
  assign countEn = (state == RUN) && !clear;

  // NOTE: default every always_comb output first so no latch is inferred.
  always_comb begin
    ctrInc           = '0;
    ctrInc[CYC_IDX]  = countEn;
    ctrInc[INST_IDX] = countEn & (retire | halt);
    for (int k = 0; k < NUM_CH; k++) begin
      ctrInc[k + CH_BASE] = countEn & ev[k];
    end
  end

  for (genvar g = 0; g < NUM_CTR; g++) begin : gCtr
    perf_ctr #(.CNT_W(CNT_W)) uCtr (
      .clk  (clk),
      .rst  (rst),
      .inc  (ctrInc[g]),
      .clr  (clear),
      .value(ctrVal[g]),
      .ovf  (ovf[g])
    );
  end

  // Out-of-range selects read as zero.
  always_comb begin
    selData = '0;
    for (int i = 0; i < NUM_CTR; i++) begin
      if (rd_sel == SEL_W'(i)) selData = ctrVal[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      rd_data  <= rd_req ? selData : '0;
    end
  end

endmodule

// File: tb/tb_perf_counter_unit.sv
// Self-checking bench for perf_counter_unit (NUM_CH=4, CNT_W=8).
module tb_perf_counter_unit;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int SEL_W  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              start, clear, retire, halt, rd_req;
  logic [NUM_CH-1:0] ev;
  logic [SEL_W-1:0]  rd_sel;
  logic              rd_valid, running, frozen;
  logic [CNT_W-1:0]  rd_data;
  logic [NUM_CH+1:0] ovf;

  int nChecks = 0;
  int nFail   = 0;

  typedef struct {
    logic [SEL_W-1:0] sel;
    logic [CNT_W-1:0] expVal;
  } rd_vec_t;

  rd_vec_t s1Tbl [8];
  logic [CNT_W-1:0] sb [$];
  logic [CNT_W-1:0] expTop;
  logic reqSeen;

  perf_counter_unit #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .retire(retire),
    .halt(halt), .ev(ev), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_valid(rd_valid), .rd_data(rd_data), .ovf(ovf),
    .running(running), .frozen(frozen)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one edge, then score the readout captured on it.
  task automatic tick();
    reqSeen = rd_req;
    @(posedge clk);
    #1;
    if (reqSeen) begin
      if (sb.size() == 0) begin
        check("scoreboard_underflow", 64'd1, 64'd0);
      end else begin
        expTop = sb.pop_front();
        check("rd_valid", {63'd0, rd_valid}, 64'd1);
        check("rd_data", {56'd0, rd_data}, {56'd0, expTop});
      end
    end else begin
      check("rd_valid_idle", {63'd0, rd_valid}, 64'd0);
      check("rd_data_idle", {56'd0, rd_data}, 64'd0);
    end
    rd_req = 1'b0;
  endtask

  task automatic read_req(input logic [SEL_W-1:0] sel, input logic [CNT_W-1:0] exp);
    rd_req = 1'b1;
    rd_sel = sel;
    sb.push_back(exp);
  endtask

  task automatic run_table();
    for (int i = 0; i < 8; i++) begin
      read_req(s1Tbl[i].sel, s1Tbl[i].expVal);
      tick();
    end
  endtask

  initial begin
    s1Tbl[0] = '{3'd0, 8'd11};
    s1Tbl[1] = '{3'd1, 8'd11};
    s1Tbl[2] = '{3'd2, 8'd10};
    s1Tbl[3] = '{3'd3, 8'd0};
    s1Tbl[4] = '{3'd4, 8'd10};
    s1Tbl[5] = '{3'd5, 8'd0};
    s1Tbl[6] = '{3'd6, 8'd0};
    s1Tbl[7] = '{3'd7, 8'd0};

    rst = 1'b0; start = 0; clear = 0; retire = 0; halt = 0; ev = '0;
    rd_req = 0; rd_sel = '0;
    #12;
    check("reset_running", {63'd0, running}, 64'd0);
    check("reset_ovf", {58'd0, ovf}, 64'd0);
    rst = 1'b1;
    tick();
    check("idle_frozen", {63'd0, frozen}, 64'd0);

    // Scenario 1
    start = 1; tick(); start = 0;
    check("s1_running", {63'd0, running}, 64'd1);
    retire = 1; ev = 4'b0101;
    repeat (10) tick();
    retire = 0; ev = '0; halt = 1;
    tick();
    halt = 0;
    check("s1_frozen", {63'd0, frozen}, 64'd1);
    check("s1_not_running", {63'd0, running}, 64'd0);
    run_table();

    // Scenario 2: activity while frozen changes nothing
    ev = 4'hF; retire = 1; start = 1;
    repeat (20) tick();
    ev = '0; retire = 0; start = 0;
    check("s2_frozen", {63'd0, frozen}, 64'd1);
    run_table();

    // Scenario 3: overflow of channel 0
    clear = 1; tick(); clear = 0;
    check("clr_frozen", {63'd0, frozen}, 64'd0);
    start = 1; tick(); start = 0;
    ev = 4'b0001;
    repeat (257) tick();
    ev = '0;
    check("s3_ovf_ch0", {63'd0, ovf[2]}, 64'd1);
    check("s3_ovf_ch1", {63'd0, ovf[3]}, 64'd0);
    check("s3_ovf_inst", {63'd0, ovf[1]}, 64'd0);
`ifdef PERF_SATURATE_EN
    read_req(3'd2, 8'd255); tick();
`else
    read_req(3'd2, 8'd1); tick();
`endif
    read_req(3'd1, 8'd0); tick();

    // Scenario 4: clear beats halt, start and events
    clear = 1; halt = 1; start = 1; retire = 1; ev = 4'hF;
    tick();
    clear = 0; halt = 0; start = 0; retire = 0; ev = '0;
    check("s4_running", {63'd0, running}, 64'd0);
    check("s4_frozen", {63'd0, frozen}, 64'd0);
    check("s4_ovf", {58'd0, ovf}, 64'd0);
    for (int i = 0; i < 6; i++) begin
      read_req(SEL_W'(i), 8'd0);
      tick();
    end

    // Scenario 5: readout returns the pre-update value
    start = 1; tick(); start = 0;
    retire = 1;
    repeat (5) tick();
    read_req(3'd1, 8'd5); tick();
    retire = 0;
    read_req(3'd7, 8'd0); tick();
    tick();
    read_req(3'd1, 8'd6); tick();

    // Scenario 6: async reset mid-run with a readout in flight
    ev = 4'b0010;
    repeat (3) tick();
    rd_req = 1; rd_sel = 3'd0;
    @(posedge clk); #2;
    check("s6_valid_before", {63'd0, rd_valid}, 64'd1);
    rst = 1'b0;
    #1;
    check("s6_rd_valid", {63'd0, rd_valid}, 64'd0);
    check("s6_rd_data", {56'd0, rd_data}, 64'd0);
    check("s6_running", {63'd0, running}, 64'd0);
    check("s6_frozen", {63'd0, frozen}, 64'd0);
    check("s6_ovf", {58'd0, ovf}, 64'd0);
    @(posedge clk); #1;
    check("s6_hold_valid", {63'd0, rd_valid}, 64'd0);
    rd_req = 0; ev = '0;
    rst = 1'b1;
    @(negedge clk);
    read_req(3'd0, 8'd0); tick();
    read_req(3'd4, 8'd0); tick();
    check("s6_idle", {63'd0, running}, 64'd0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
